buffer_load_ctrl: RTL and testbench

- Upstream feeder of the sequence buffer.
- Accepts query/database beats from the host interface over a valid/ready handshake and generates the buffer write strobe and register index.
- Presents beat data registered, aligned with the write strobe and index.
- Tracks when a complete pair of sequences is resident and holds it until the alignment controller releases it.

---
 rtl/buffer_load_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_buffer_load_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_load_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_load_ctrl
//
// Upstream feeder of the sequence buffer. Accepts query/database beats from the
// host over a valid/ready handshake, turns each accepted beat into a one-cycle
// buffer write (strobe + register index + registered beat data), and tracks
// when a complete query/database pair is resident until the alignment
// controller releases it.
//
// Optional feature (compile-time macro BUFF_LOAD_TIMEOUT_EN):
//   When defined, a stall counter aborts a LOAD that has gone TIMEOUT_CYCLES
//   consecutive cycles without an accepted beat, and pulses load_err.
//   When undefined, load_err is tied low and LOAD waits indefinitely.
//
// Ports:
//   clk               in   rising-edge clock
//   rst_n             in   synchronous active-low reset
//   start             in   one-cycle request to begin loading a new pair
//   release_seq       in   alignment controller done with resident pair
//   abort             in   cancel an in-progress load
//   in_valid          in   host beat valid
//   in_ready          out  block can accept a beat (LOAD and no abort)
//   query_in          in   query beat
//   database_in       in   database beat
//   wr_en_buff        out  buffer write strobe, one cycle per accepted beat
//   count             out  buffer register index of the current write
//   query_data_out    out  registered query beat (0 when not writing)
//   database_data_out out  registered database beat (0 when not writing)
//   load_done         out  pulse concurrent with the final write of a load
//   seq_ready         out  level, buffer holds a complete pair
//   busy              out  high while in LOAD
//   load_err          out  pulse on timeout abort
// -----------------------------------------------------------------------------
module buffer_load_ctrl #(
  parameter int NUM_BUFF_REGS  = 4,
  parameter int BUFF_CNT_W     = 2,
  parameter int INPUT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   release_seq,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] query_in,
  input  logic [INPUT_WIDTH-1:0] database_in,
  output logic                   wr_en_buff,
  output logic [BUFF_CNT_W-1:0]  count,
  output logic [INPUT_WIDTH-1:0] query_data_out,
  output logic [INPUT_WIDTH-1:0] database_data_out,
  output logic                   load_done,
  output logic                   seq_ready,
  output logic                   busy,
  output logic                   load_err
);

  // Reject parameter sets the index/terminal-count logic cannot represent.
  if (NUM_BUFF_REGS < 2 || TIMEOUT_CYCLES < 1 ||
      (1 << BUFF_CNT_W) < NUM_BUFF_REGS) begin : g_bad_cfg
    $error("buffer_load_ctrl: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam logic [BUFF_CNT_W-1:0] LAST_IDX = BUFF_CNT_W'(NUM_BUFF_REGS - 1);
  localparam logic [BUFF_CNT_W-1:0] CNT_ONE  = BUFF_CNT_W'(1);

  state_e                 state_q,     state_d;
  logic [BUFF_CNT_W-1:0]  beat_cnt_q,  beat_cnt_d;
  logic                   wr_en_q,     wr_en_d;
  logic [BUFF_CNT_W-1:0]  count_q,     count_d;
  logic [INPUT_WIDTH-1:0] q_data_q,    q_data_d;
  logic [INPUT_WIDTH-1:0] db_data_q,   db_data_d;
  logic                   load_done_q, load_done_d;
  logic                   seq_ready_q, seq_ready_d;

  logic accept;
  logic timeout;

  // in_ready depends only on state and abort, so a combinational path from
  // in_valid back to in_ready can never form.
  assign in_ready = (state_q == ST_LOAD) && !abort;
  assign accept   = in_valid && in_ready;

`ifdef BUFF_LOAD_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               load_err_q;

  // The cycle whose idle edge would bring the counter to TIMEOUT_CYCLES is
  // the timeout cycle; an abort in the same cycle takes precedence.
  assign timeout = (state_q == ST_LOAD) && !abort && !accept &&
                   (stall_q == STALL_LAST);

  always_comb begin
    stall_d = '0;
    if (state_q == ST_LOAD && !accept && !timeout) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      stall_q    <= stall_d;
      load_err_q <= timeout;
    end
  end

  assign load_err = load_err_q;
`else
  assign timeout  = 1'b0;
  assign load_err = 1'b0;
`endif

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    seq_ready_d = 1'b0;

    // Write-side outputs are pure functions of this cycle's accept; the data
    // and index are zeroed when no write is happening.
    wr_en_d     = accept;
    count_d     = accept ? beat_cnt_q  : '0;
    q_data_d    = accept ? query_in    : '0;
    db_data_d   = accept ? database_in : '0;
    load_done_d = accept && (beat_cnt_q == LAST_IDX);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          beat_cnt_d = '0;
        end
      end

      ST_LOAD: begin
        if (abort || timeout) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end else if (accept) begin
          if (beat_cnt_q == LAST_IDX) begin
            // Leaving at the terminal count means the counter never wraps.
            state_d    = ST_FULL;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end
        end
      end

      ST_FULL: begin
        // seq_ready trails load_done by one cycle, so the final write has
        // committed before the pair is advertised.
        if (release_seq) begin
          state_d = ST_IDLE;
        end else begin
          seq_ready_d = 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // NOTE: the reset is synchronous, so it lives inside the clocked branch
  // rather than in the sensitivity list; all state uses non-blocking
  // assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      count_q     <= '0;
      q_data_q    <= '0;
      db_data_q   <= '0;
      load_done_q <= 1'b0;
      seq_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_en_q     <= wr_en_d;
      count_q     <= count_d;
      q_data_q    <= q_data_d;
      db_data_q   <= db_data_d;
      load_done_q <= load_done_d;
      seq_ready_q <= seq_ready_d;
    end
  end

  assign wr_en_buff        = wr_en_q;
  assign count             = count_q;
  assign query_data_out    = q_data_q;
  assign database_data_out = db_data_q;
  assign load_done         = load_done_q;
  assign seq_ready         = seq_ready_q;
  assign busy              = (state_q == ST_LOAD);

endmodule

// File: tb/tb_buffer_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buffer_load_ctrl
//
// Directed bench for buffer_load_ctrl with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// i.e. they show what the edge just registered. Timeout expectations follow
// BUFF_LOAD_TIMEOUT_EN with TIMEOUT_CYCLES = 8.
// -----------------------------------------------------------------------------
module tb_buffer_load_ctrl;

  localparam int NR = 4;
  localparam int CW = 2;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, release_seq, abort, in_valid;
  logic          in_ready, wr_en_buff, load_done, seq_ready, busy, load_err;
  logic [IW-1:0] query_in, database_in, query_data_out, database_data_out;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  buffer_load_ctrl #(
    .NUM_BUFF_REGS (NR),
    .BUFF_CNT_W    (CW),
    .INPUT_WIDTH   (IW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .release_seq      (release_seq),
    .abort            (abort),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .query_in         (query_in),
    .database_in      (database_in),
    .wr_en_buff       (wr_en_buff),
    .count            (count),
    .query_data_out   (query_data_out),
    .database_data_out(database_data_out),
    .load_done        (load_done),
    .seq_ready        (seq_ready),
    .busy             (busy),
    .load_err         (load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every output packed together; all zero after reset.
  function automatic logic [2*IW+CW+5:0] all_outs();
    return {in_ready, wr_en_buff, load_done, seq_ready, busy, load_err,
            count, query_data_out, database_data_out};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; release_seq = 1'b0; abort = 1'b0;
    in_valid = 1'b0; query_in = '0; database_in = '0;
    tick(); tick();
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_outs: got %h expected 0", all_outs());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_load();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_enter_load: busy=%b in_ready=%b expected 1 1", busy, in_ready);
    end
    for (int i = 0; i < NR; i++) begin
      in_valid    = 1'b1;
      query_in    = 32'h11111111 * (i + 1);
      database_in = 32'hD0000000 | i;
      tick();
      checks++;
      if (wr_en_buff !== 1'b1 || count !== CW'(i) ||
          query_data_out !== 32'h11111111 * (i + 1) ||
          database_data_out !== (32'hD0000000 | i) || load_done !== (i == NR - 1)) begin
        failures++;
        $display("FAIL basic_write%0d: wr=%b cnt=%0d q=%h d=%h done=%b expected 1 %0d %h %h %b",
                 i, wr_en_buff, count, query_data_out, database_data_out, load_done,
                 i, 32'h11111111 * (i + 1), 32'hD0000000 | i, i == NR - 1);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (seq_ready !== 1'b1 || wr_en_buff !== 1'b0 || count !== '0 ||
        query_data_out !== '0 || database_data_out !== '0 ||
        busy !== 1'b0 || in_ready !== 1'b0 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_full: seq_ready=%b wr=%b cnt=%0d q=%h d=%h busy=%b rdy=%b done=%b expected 1 0 0 0 0 0 0 0",
               seq_ready, wr_en_buff, count, query_data_out, database_data_out,
               busy, in_ready, load_done);
    end
  endtask

  task automatic test_full_hold();
    start = 1'b1; in_valid = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_in_ready: got %b expected 0", in_ready);
    end
    tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_en_buff !== 1'b0 || seq_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL full_hold%0d: wr=%b seq_ready=%b busy=%b expected 0 1 0",
                 k, wr_en_buff, seq_ready, busy);
      end
      tick();
    end
    in_valid = 1'b0;
    // start coinciding with release_seq must not begin a new load.
    release_seq = 1'b1; start = 1'b1; tick(); release_seq = 1'b0; start = 1'b0;
    checks++;
    if (seq_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_release: seq_ready=%b busy=%b expected 0 0", seq_ready, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL full_start_ignored: busy=%b expected 0", busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; query_in = 32'hCAFE0000; database_in = 32'hBEEF0000;
    tick();
    checks++;
    if (wr_en_buff !== 1'b1 || count !== '0 || query_data_out !== 32'hCAFE0000) begin
      failures++;
      $display("FAIL full_reload: wr=%b cnt=%0d q=%h expected 1 0 cafe0000",
               wr_en_buff, count, query_data_out);
    end
    repeat (NR - 1) tick();
    in_valid = 1'b0;
    tick();
    release_seq = 1'b1; tick(); release_seq = 1'b0;
  endtask

  task automatic test_valid_gaps();
    logic [10:0] pat = 11'h219;  // valid on cycles 0, 3, 4, 9
    int exp_idx = 0;
    int n_wr = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      in_valid    = pat[c];
      query_in    = 32'hA0000000 + c;
      database_in = 32'hB0000000 + c;
      tick();
      if (wr_en_buff === 1'b1) n_wr++;
      checks++;
      if (pat[c]) begin
        if (wr_en_buff !== 1'b1 || count !== CW'(exp_idx) ||
            query_data_out !== 32'hA0000000 + c || database_data_out !== 32'hB0000000 + c ||
            load_done !== (exp_idx == NR - 1)) begin
          failures++;
          $display("FAIL gaps_write_c%0d: wr=%b cnt=%0d q=%h d=%h done=%b expected 1 %0d %h %h %b",
                   c, wr_en_buff, count, query_data_out, database_data_out, load_done,
                   exp_idx, 32'hA0000000 + c, 32'hB0000000 + c, exp_idx == NR - 1);
        end
        exp_idx++;
      end else if (wr_en_buff !== 1'b0 || count !== '0 || load_done !== 1'b0) begin
        failures++;
        $display("FAIL gaps_idle_c%0d: wr=%b cnt=%0d done=%b expected 0 0 0",
                 c, wr_en_buff, count, load_done);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_wr != NR || seq_ready !== 1'b1) begin
      failures++;
      $display("FAIL gaps_total: writes=%0d seq_ready=%b expected %0d 1", n_wr, seq_ready, NR);
    end
    release_seq = 1'b1; tick(); release_seq = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; query_in = 32'h5500 + i; database_in = 32'h6600 + i;
      tick();
      checks++;
      if (wr_en_buff !== 1'b1 || count !== CW'(i)) begin
        failures++;
        $display("FAIL abort_pre%0d: wr=%b cnt=%0d expected 1 %0d", i, wr_en_buff, count, i);
      end
    end
    abort = 1'b1; query_in = 32'h5502; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_ready: got %b expected 0", in_ready);
    end
    tick(); abort = 1'b0;
    checks++;
    if (wr_en_buff !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || query_data_out !== '0) begin
      failures++;
      $display("FAIL abort_no_write: wr=%b busy=%b done=%b q=%h expected 0 0 0 0",
               wr_en_buff, busy, load_done, query_data_out);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (seq_ready !== 1'b0 || wr_en_buff !== 1'b0 || load_done !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle%0d: seq_ready=%b wr=%b done=%b expected 0 0 0",
                 k, seq_ready, wr_en_buff, load_done);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (wr_en_buff !== 1'b1 || count !== '0) begin
      failures++;
      $display("FAIL abort_restart: wr=%b cnt=%0d expected 1 0", wr_en_buff, count);
    end
    in_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_reset_midload();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; query_in = 32'h77777777; database_in = 32'h88888888;
    repeat (3) tick();
    rst_n = 1'b0; tick();
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL midload_reset_outs: got %h expected 0", all_outs());
    end
    rst_n = 1'b1; tick();
    checks++;
    if (wr_en_buff !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midload_no_4th: wr=%b busy=%b expected 0 0", wr_en_buff, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_err, exp_busy;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; query_in = 32'h99999999; tick(); in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
`ifdef BUFF_LOAD_TIMEOUT_EN
      exp_err  = (k == 8);
      exp_busy = (k < 8);
`else
      exp_err  = 1'b0;
      exp_busy = 1'b1;
`endif
      checks++;
      if (load_err !== exp_err || busy !== exp_busy) begin
        failures++;
        $display("FAIL timeout_c%0d: load_err=%b busy=%b expected %b %b",
                 k, load_err, busy, exp_err, exp_busy);
      end
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_full_hold();
    test_valid_gaps();
    test_abort();
    test_reset_midload();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
